uart_bus_sequencer: RTL
=======================

// Module: uart_bus_sequencer
// PURPOSE
// Autonomous master for the UART register-file bus; replaces processor polling.
// - Configures the UART on request: disable, baud write, control write, read-back check.
// - Then moves bytes: stream TX bytes into DATA_REG, drain RX bytes out to a stream.
// - Round-robin arbitration between TX and RX traffic; sticky line-error capture.
// PARAMETERS
// CFG_TIMEOUT 1024  max cycles to wait for status.busy=0 during configuration
// TO_W        11    timeout counter width, >= clog2(CFG_TIMEOUT+1)
// PORTS
// clock         in   1   system clock; all state on posedge
// reset         in   1   asynchronous, active-low (0 = reset)
// cfg_start     in   1   1-cycle pulse: start the config sequence; ignored unless in IDLE/RUN
// cfg_baud      in   16  baud divisor; sampled when cfg_start is accepted
// cfg_ctrl      in   8   CTRL_REG image; sampled with cfg_baud
// cfg_done      out  1   1-cycle pulse: config finished, read-back matched
// cfg_err       out  1   sticky: timeout or read-back mismatch; cleared by next cfg_start
// run           out  1   1 while byte traffic is enabled
// tx_data       in   8   byte to transmit
// tx_valid      in   1   tx_data valid
// tx_ready      out  1   1-cycle pulse: tx_data written to UART this cycle
// rx_data       out  8   received byte, held stable while rx_valid=1
// rx_valid      out  1   rx_data valid; held until rx_ready
// rx_ready      in   1   consumer accepts rx_data
// err_flags     out  2   sticky {parity_error, stop_bit_error}
// err_clr       in   1   clears err_flags; a same-cycle new error wins
// uart_sel      out  1   register-file select
// uart_wr_enable out 1   register-file write strobe
// uart_addr     out  4   register address (package constants)
// wdata_mem     out  32  write data, zero-extended
// uart_data     in   32  register read data (combinational in the register file)
// BEHAVIOUR
// Reset: state=IDLE; run=0; cfg_done=0; cfg_err=0; tx_ready=0; rx_valid=0;
//   rx_data=0; err_flags=0; uart_sel=0; uart_wr_enable=0; uart_addr=STATUS_REG; wdata_mem=0.
// Bus default, every cycle not listed below: addr=STATUS_REG, sel=0, wr=0.
// Bus outputs are registered on posedge; the register file samples on the following negedge.
// Bus rules:
// - Write: wr=1, sel=0, for exactly 1 cycle.
// - DATA_REG read: sel=1, wr=0, for exactly 1 cycle (one RX FIFO pop).
// - Never drive DATA_REG with sel=1 in any other cycle.
// Status bits: [5] tx_full, [4] rx_full, [3] rx_empty, [2] parity_err, [1] stop_err, [0] busy.
// FSM states: IDLE, CFG_WAIT, CFG_OFF, CFG_BAUD, CFG_CTRL, CFG_CHK, RUN_POLL, RUN_TX, RUN_RX.
// - IDLE -cfg_start-> CFG_WAIT: run=0, cfg_err=0, timeout counter=0.
// - CFG_WAIT: read STATUS each cycle.
//   - busy=0 -> CFG_OFF.
//   - Counter reaches CFG_TIMEOUT -> cfg_err=1, IDLE.
// - CFG_OFF: write CTRL_REG=0 (uart_en=0, which unlocks BAUD_REG) -> CFG_BAUD.
// - CFG_BAUD: write BAUD_REG = {16'b0, cfg_baud} -> CFG_CTRL.
// - CFG_CTRL: write CTRL_REG = {24'b0, cfg_ctrl} -> CFG_CHK.
// - CFG_CHK: read CTRL_REG and compare uart_data[7:0] to cfg_ctrl.
//   - Match -> cfg_done pulse, run=1, RUN_POLL.
//   - Mismatch -> cfg_err=1, IDLE.
// - RUN_POLL: read STATUS; OR bits [2:1] into err_flags. Eligibility:
//   - TX eligible: tx_valid && !tx_full.
//   - RX eligible: !rx_empty && !rx_valid.
//   - Both eligible: grant the side not granted last; the grant pointer toggles only on a grant.
//   - Neither eligible: stay in RUN_POLL.
// - RUN_TX: write DATA_REG = {24'b0, tx_data}; tx_ready=1 this cycle -> RUN_POLL.
// - RUN_RX: DATA_REG read; capture uart_data[7:0] into rx_data; rx_valid=1 next cycle -> RUN_POLL.
// rx_valid falls the cycle after rx_valid && rx_ready; at most one byte is buffered.
// Throughput: one byte per 2 cycles per direction when the other side is idle.
// cfg_start in a RUN_* state is taken only at RUN_POLL (never mid-access) -> CFG_WAIT.
// Reset asserted mid-sequence: immediate return to reset values; no partial bus cycle completes.
// STRUCTURE
// Package `packages` holds: STATUS_REG/DATA_REG/CTRL_REG/BAUD_REG, the status-bit index
// localparams, and typedef enum seq_state_e. Single module; no sub-module needed.
// TESTING
// Config: baud=16'h0036, ctrl=8'h9C, busy=0 -> bus writes CTRL=0, BAUD=0x36, CTRL=0x9C; cfg_done at CFG_CHK+1.
// Timeout: busy held 1 -> cfg_err=1 after exactly 1024 CFG_WAIT cycles; no write issued.
// TX stream: 0x41,0x42,0x43 with tx_full=0 -> three DATA writes, sel=0, 2 cycles apart.
//   Then tx_full=1 -> no writes, tx_ready=0.
// RX with backpressure: rx_empty=0, rx_data=0x5A, rx_ready=0 -> exactly one sel=1 DATA read;
//   rx_valid held, no further pops until rx_ready.
// Contention: tx_valid=1 and rx_empty=0 continuously -> grants alternate TX,RX,TX,RX.
// Errors: parity bit=1 in one poll -> err_flags=2'b10 sticky; err_clr -> 0; async reset mid-CFG_BAUD -> all outputs at reset values.

Source files
------------

// File: rtl/uart_bus_sequencer_pkg.sv
// Shared definitions for the UART bus sequencer.
//   - Register-file addresses driven on uart_addr.
//   - Bit positions inside the STATUS register image.
//   - Sequencer FSM state encoding (also exported on the debug port).
//   - zext8: zero-extends a byte onto the 32-bit write-data bus.
package packages;

  // Register-file addresses
  localparam logic [3:0] STATUS_REG = 4'h0;
  localparam logic [3:0] DATA_REG   = 4'h1;
  localparam logic [3:0] CTRL_REG   = 4'h2;
  localparam logic [3:0] BAUD_REG   = 4'h3;

  // STATUS register bit positions
  localparam int ST_TX_FULL  = 5;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_PARITY   = 2;
  localparam int ST_STOP     = 1;
  localparam int ST_BUSY     = 0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CFG_WAIT = 4'd1,
    CFG_OFF  = 4'd2,
    CFG_BAUD = 4'd3,
    CFG_CTRL = 4'd4,
    CFG_CHK  = 4'd5,
    RUN_POLL = 4'd6,
    RUN_TX   = 4'd7,
    RUN_RX   = 4'd8
  } seq_state_e;

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/uart_bus_sequencer_if.sv
// Register-file bus between the sequencer (master) and the UART register
// file (slave).
//   uart_sel       master->slave  select; with DATA_REG and wr=0 it pops the RX FIFO
//   uart_wr_enable master->slave  write strobe
//   uart_addr      master->slave  register address (packages::*_REG)
//   wdata_mem      master->slave  write data
//   uart_data      slave->master  read data, combinational on uart_addr
interface uart_bus_sequencer_if;
  logic        uart_sel;
  logic        uart_wr_enable;
  logic [3:0]  uart_addr;
  logic [31:0] wdata_mem;
  logic [31:0] uart_data;

  modport master (
    output uart_sel,
    output uart_wr_enable,
    output uart_addr,
    output wdata_mem,
    input  uart_data
  );

  modport slave (
    input  uart_sel,
    input  uart_wr_enable,
    input  uart_addr,
    input  wdata_mem,
    output uart_data
  );
endinterface

// File: rtl/uart_bus_sequencer.sv
// Autonomous master for the UART register-file bus.
// Configures the UART (disable, baud write, control write, read-back check),
// then moves bytes between the TX/RX streams and DATA_REG with round-robin
// arbitration and sticky line-error capture.
// Ports:
//   clock, reset             clock; asynchronous active-low reset
//   cfg_start/cfg_baud/cfg_ctrl  start pulse and configuration values
//   cfg_done, cfg_err, run   configuration result and traffic enable
//   tx_data/tx_valid/tx_ready    TX byte stream in
//   rx_data/rx_valid/rx_ready    RX byte stream out
//   err_flags, err_clr       sticky {parity, stop} errors and their clear
//   bus                      register-file bus (master modport)
//   state_dbg                current FSM state
//
// Stream handshakes: a producer holds tx_data stable while tx_valid=1; the
// byte is consumed in the single cycle where tx_ready=1. rx_data is held
// stable while rx_valid=1; the byte is consumed on a cycle with
// rx_valid && rx_ready and rx_valid drops on the following cycle.
module uart_bus_sequencer
  import packages::*;
#(
  parameter int CFG_TIMEOUT = 1024,
  parameter int TO_W        = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [15:0]          cfg_baud,
  input  logic [7:0]           cfg_ctrl,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 run,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [1:0]           err_flags,
  input  logic                 err_clr,
  uart_bus_sequencer_if.master bus,
  output seq_state_e           state_dbg
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CFG_TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [15:0]     baud_q;
  logic [7:0]      ctrl_q;
  logic            cfg_pend_q;
  logic            last_rx_q;   // 1: most recent grant went to RX

  logic [31:0] rd;
  logic        ctrl_match, tx_elig, rx_elig;
  logic        cfg_take, tx_grant, rx_grant;
  logic        cfg_accept_window, to_expire, chk_fail;

  // Next-cycle bus / strobe values, registered below
  logic        sel_d, wr_d, tx_ready_d;
  logic [3:0]  addr_d;
  logic [31:0] wdata_d;

  logic unused_data_hi;
  assign unused_data_hi = ^bus.uart_data[31:8];

  assign rd         = bus.uart_data;
  assign ctrl_match = (rd[7:0] == ctrl_q);
  // Status bits are meaningful only in states whose address is STATUS_REG
  assign tx_elig    = tx_valid && !rd[ST_TX_FULL];
  assign rx_elig    = !rd[ST_RX_EMPTY] && !rx_valid;
  assign to_expire  = (state_q == CFG_WAIT) && rd[ST_BUSY] && (to_cnt_q == TO_LAST);
  assign chk_fail   = (state_q == CFG_CHK) && !ctrl_match;
  assign state_dbg  = state_q;

  // cfg_start is sampled in IDLE and any RUN_* state; during a RUN_TX/RUN_RX
  // access it is remembered and acted on at the next RUN_POLL.
  assign cfg_accept_window = (state_q == IDLE) || (state_q == RUN_POLL) ||
                             (state_q == RUN_TX) || (state_q == RUN_RX);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and arbitration
  always_comb begin
    state_d  = state_q;
    cfg_take = 1'b0;
    tx_grant = 1'b0;
    rx_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = CFG_WAIT;
          cfg_take = 1'b1;
        end
      end
      CFG_WAIT: begin
        if (!rd[ST_BUSY])  state_d = CFG_OFF;
        else if (to_expire) state_d = IDLE;
      end
      CFG_OFF:  state_d = CFG_BAUD;
      CFG_BAUD: state_d = CFG_CTRL;
      CFG_CTRL: state_d = CFG_CHK;
      CFG_CHK:  state_d = ctrl_match ? RUN_POLL : IDLE;
      RUN_POLL: begin
        if (cfg_start || cfg_pend_q) begin
          state_d  = CFG_WAIT;
          cfg_take = 1'b1;
        end else if (tx_elig && rx_elig) begin
          tx_grant = last_rx_q;
          rx_grant = !last_rx_q;
        end else begin
          tx_grant = tx_elig;
          rx_grant = rx_elig;
        end
        if (tx_grant)      state_d = RUN_TX;
        else if (rx_grant) state_d = RUN_RX;
      end
      RUN_TX:  state_d = RUN_POLL;
      RUN_RX:  state_d = RUN_POLL;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: bus access for the state being entered, so the registered
  // bus lines line up with the state that owns the access.
  always_comb begin
    sel_d      = 1'b0;
    wr_d       = 1'b0;
    addr_d     = STATUS_REG;
    wdata_d    = 32'h0;
    tx_ready_d = 1'b0;
    case (state_d)
      CFG_OFF: begin
        wr_d   = 1'b1;
        addr_d = CTRL_REG;
      end
      CFG_BAUD: begin
        wr_d    = 1'b1;
        addr_d  = BAUD_REG;
        wdata_d = {16'b0, baud_q};
      end
      CFG_CTRL: begin
        wr_d    = 1'b1;
        addr_d  = CTRL_REG;
        wdata_d = zext8(ctrl_q);
      end
      CFG_CHK: addr_d = CTRL_REG;
      RUN_TX: begin
        wr_d       = 1'b1;
        addr_d     = DATA_REG;
        wdata_d    = zext8(tx_data);
        tx_ready_d = 1'b1;
      end
      RUN_RX: begin
        sel_d  = 1'b1;
        addr_d = DATA_REG;
      end
      default: ;
    endcase
  end

  // Registered bus and stream strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.uart_sel       <= 1'b0;
      bus.uart_wr_enable <= 1'b0;
      bus.uart_addr      <= STATUS_REG;
      bus.wdata_mem      <= 32'h0;
      tx_ready           <= 1'b0;
    end else begin
      bus.uart_sel       <= sel_d;
      bus.uart_wr_enable <= wr_d;
      bus.uart_addr      <= addr_d;
      bus.wdata_mem      <= wdata_d;
      tx_ready           <= tx_ready_d;
    end
  end

  // Configuration bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q   <= '0;
      baud_q     <= 16'h0;
      ctrl_q     <= 8'h0;
      cfg_pend_q <= 1'b0;
      run        <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      // Counter is zero on entry to CFG_WAIT and counts each cycle spent there
      to_cnt_q <= (state_q == CFG_WAIT) ? to_cnt_q + TO_W'(1) : '0;
      if (cfg_start && cfg_accept_window) begin
        baud_q <= cfg_baud;
        ctrl_q <= cfg_ctrl;
      end
      if (state_q == RUN_POLL)
        cfg_pend_q <= 1'b0;
      else if (cfg_start && (state_q == RUN_TX || state_q == RUN_RX))
        cfg_pend_q <= 1'b1;
      cfg_done <= (state_q == CFG_CHK) && ctrl_match;
      if (cfg_take)
        run <= 1'b0;
      else if ((state_q == CFG_CHK) && ctrl_match)
        run <= 1'b1;
      if (cfg_take)
        cfg_err <= 1'b0;
      else if (to_expire || chk_fail)
        cfg_err <= 1'b1;
    end
  end

  // Byte traffic and error capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_rx_q <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h0;
      err_flags <= 2'b00;
    end else begin
      if (tx_grant)      last_rx_q <= 1'b0;
      else if (rx_grant) last_rx_q <= 1'b1;
      if (state_q == RUN_RX) begin
        rx_valid <= 1'b1;
        rx_data  <= rd[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A new error in the same cycle as err_clr survives the clear
      err_flags <= (err_clr ? 2'b00 : err_flags) |
                   ((state_q == RUN_POLL) ? {rd[ST_PARITY], rd[ST_STOP]} : 2'b00);
    end
  end

endmodule
